// File: rtl/pfd_tdc.sv
// Phase-frequency detector with a time-to-digital counter.
// Measures the phase difference between two asynchronous clocks (ref, fb)
// in clk_in cycles and reports it as a saturated signed value.
module pfd_tdc #(
  parameter int CNT_W = 8
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    ref_in,
  input  logic                    fb_in,
  input  logic                    enable,
  output logic signed [CNT_W-1:0] phase_err,
  output logic                    err_valid,
  output logic                    up,
  output logic                    dn,
  output logic                    slip
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REF_LEAD = 2'd1,
    FB_LEAD  = 2'd2
  } state_t;

  localparam logic signed [CNT_W-1:0] ZERO    = '0;
  localparam logic signed [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic signed [CNT_W-1:0] MAX_POS = {1'b0, {(CNT_W-1){1'b1}}};

  // Counter step that sticks at the positive limit instead of wrapping.
  function automatic logic signed [CNT_W-1:0] sat_inc(input logic signed [CNT_W-1:0] v);
    return (v >= MAX_POS) ? MAX_POS : v + ONE;
  endfunction

  // Negation for the fb-leads case; cnt never exceeds MAX_POS, so the
  // result never reaches the most negative code.
  function automatic logic signed [CNT_W-1:0] sat_neg(input logic signed [CNT_W-1:0] v);
    return (v >= MAX_POS) ? (ZERO - MAX_POS) : (ZERO - v);
  endfunction

  logic   ref_s1_q, ref_s2_q, ref_h_q;
  logic   fb_s1_q,  fb_s2_q,  fb_h_q;
  logic   ref_s1_d, ref_s2_d, ref_h_d;
  logic   fb_s1_d,  fb_s2_d,  fb_h_d;
  logic   ref_rise, fb_rise;

  state_t                  state_q, state_d;
  logic signed [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [CNT_W-1:0] perr_q, perr_d;
  logic                    vld_q, vld_d;
  logic                    slip_q, slip_d;

  // Synchronizer chain and history stage for both input clocks; runs regardless of enable.
  always_comb begin
    ref_s1_d = ref_in;
    ref_s2_d = ref_s1_q;
    ref_h_d  = ref_s2_q;
    fb_s1_d  = fb_in;
    fb_s2_d  = fb_s1_q;
    fb_h_d   = fb_s2_q;
  end

  assign ref_rise = ref_s2_q & ~ref_h_q;
  assign fb_rise  = fb_s2_q  & ~fb_h_q;

  // Synchronizer registers.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      ref_s1_q <= 1'b0;
      ref_s2_q <= 1'b0;
      ref_h_q  <= 1'b0;
      fb_s1_q  <= 1'b0;
      fb_s2_q  <= 1'b0;
      fb_h_q   <= 1'b0;
    end else begin
      ref_s1_q <= ref_s1_d;
      ref_s2_q <= ref_s2_d;
      ref_h_q  <= ref_h_d;
      fb_s1_q  <= fb_s1_d;
      fb_s2_q  <= fb_s2_d;
      fb_h_q   <= fb_h_d;
    end
  end

  // Measurement FSM: next state, interval counter and result registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    perr_d  = perr_q;
    vld_d   = 1'b0;
    slip_d  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = ZERO;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ref_rise && fb_rise) begin
            perr_d = ZERO;
            vld_d  = 1'b1;
          end else if (ref_rise) begin
            state_d = REF_LEAD;
            cnt_d   = ONE;
          end else if (fb_rise) begin
            state_d = FB_LEAD;
            cnt_d   = ONE;
          end
        end
        REF_LEAD: begin
          if (fb_rise && ref_rise) begin
            // Closing edge doubles as the opening edge of the next interval.
            perr_d = cnt_q;
            vld_d  = 1'b1;
            cnt_d  = ONE;
          end else if (fb_rise) begin
            perr_d  = cnt_q;
            vld_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = ZERO;
          end else if (ref_rise) begin
            perr_d = MAX_POS;
            vld_d  = 1'b1;
            slip_d = 1'b1;
            cnt_d  = ONE;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        FB_LEAD: begin
          if (ref_rise && fb_rise) begin
            perr_d = sat_neg(cnt_q);
            vld_d  = 1'b1;
            cnt_d  = ONE;
          end else if (ref_rise) begin
            perr_d  = sat_neg(cnt_q);
            vld_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = ZERO;
          end else if (fb_rise) begin
            perr_d = ZERO - MAX_POS;
            vld_d  = 1'b1;
            slip_d = 1'b1;
            cnt_d  = ONE;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = ZERO;
        end
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= ZERO;
      perr_q  <= ZERO;
      vld_q   <= 1'b0;
      slip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
      vld_q   <= vld_d;
      slip_q  <= slip_d;
    end
  end

  assign phase_err = perr_q;
  assign err_valid = vld_q;
  assign slip      = slip_q;
  assign up        = (state_q == REF_LEAD);
  assign dn        = (state_q == FB_LEAD);

endmodule

// File: tb/tb_pfd_tdc.sv
// Scoreboard bench for pfd_tdc: directed ref/fb edge patterns push their
// expected results; a monitor pops and compares on every err_valid.
module tb_pfd_tdc;
  localparam int CNT_W = 8;

  logic                    clk_in = 1'b0;
  logic                    rst_n  = 1'b0;
  logic                    ref_in = 1'b0;
  logic                    fb_in  = 1'b0;
  logic                    enable = 1'b0;
  logic signed [CNT_W-1:0] phase_err;
  logic                    err_valid, up, dn, slip;

  pfd_tdc #(.CNT_W(CNT_W)) dut (
    .clk_in    (clk_in),
    .reset     (rst_n),
    .ref_in    (ref_in),
    .fb_in     (fb_in),
    .enable    (enable),
    .phase_err (phase_err),
    .err_valid (err_valid),
    .up        (up),
    .dn        (dn),
    .slip      (slip)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int perr;
    int slp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   up_cnt = 0;
  int   dn_cnt = 0;
  int   last_exp = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic push(input int p, input int s);
    exp_t e;
    e.perr = p;
    e.slp  = s;
    last_exp = p;
    exp_q.push_back(e);
  endtask

  // Monitor: every err_valid must match the oldest expected result.
  always @(negedge clk_in) begin
    if (err_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_err_valid: got phase_err %0d, expected no result", int'(phase_err));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("phase_err", int'(phase_err), e.perr);
        check("slip_flag", int'(slip), e.slp);
      end
    end else if (slip === 1'b1) begin
      checks++;
      $display("FAIL slip_without_valid: got slip 1, expected 0");
    end
  end

  // One clk_in cycle: drive inputs after the edge, sample up/dn mid-cycle.
  task automatic step(input bit r, input bit f);
    @(posedge clk_in);
    #1;
    ref_in = r;
    fb_in  = f;
    @(negedge clk_in);
    if (up === 1'b1) up_cnt++;
    if (dn === 1'b1) dn_cnt++;
  endtask

  function automatic bit hit(input int t, input int o);
    return (o >= 0) && (t >= o) && (t < o + 2);
  endfunction

  task automatic window(input int r1, input int r2, input int f1, input int f2,
                        input int len, input int exp_up, input int exp_dn);
    up_cnt = 0;
    dn_cnt = 0;
    for (int t = 0; t < len; t++)
      step(hit(t, r1) | hit(t, r2), hit(t, f1) | hit(t, f2));
    if (exp_up >= 0) check("up_cycles", up_cnt, exp_up);
    if (exp_dn >= 0) check("dn_cycles", dn_cnt, exp_dn);
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_phase_err", int'(phase_err), 0);
    check("rst_err_valid", int'(err_valid), 0);
    check("rst_up", int'(up), 0);
    check("rst_dn", int'(dn), 0);
    check("rst_slip", int'(slip), 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    window(-1, -1, -1, -1, 4, 0, 0);

    // Aligned edges.
    for (int i = 0; i < 3; i++) begin
      push(0, 0);
      window(0, -1, 0, -1, 16, 0, 0);
    end
    // ref leads by 5.
    for (int i = 0; i < 2; i++) begin
      push(5, 0);
      window(0, -1, 5, -1, 16, 5, 0);
    end
    // fb leads by 3.
    for (int i = 0; i < 2; i++) begin
      push(-3, 0);
      window(3, -1, 0, -1, 16, 0, 3);
    end
    // Coincident close/reopen in REF_LEAD, then in FB_LEAD.
    push(6, 0);
    push(4, 0);
    window(0, 6, 6, 10, 20, 10, 0);
    push(-6, 0);
    push(-4, 0);
    window(6, 10, 0, 6, 20, 0, 10);

    // ref slip after saturation, then a normal close.
    push(127, 1);
    push(10, 0);
    for (int t = 0; t < 230; t++) begin
      step(hit(t, 0) | hit(t, 200), hit(t, 210));
      if (t == 180) begin
        check("cnt_saturated", int'(dut.cnt_q), 127);
        check("up_long_lead", int'(up), 1);
      end
      if (t == 205) check("up_after_slip", int'(up), 1);
    end

    // fb leads far: magnitude saturates at -127.
    push(-127, 0);
    window(150, -1, 0, -1, 170, 0, 150);
    // fb slip, then ref closes 7 cycles after the second fb.
    push(-127, 1);
    push(-7, 0);
    window(187, -1, 0, 180, 200, 0, 187);

    // Reset pulsed inside a REF_LEAD interval.
    for (int t = 0; t < 16; t++) begin
      step(hit(t, 0), 1'b0);
      if (t == 5) check("up_before_reset", int'(up), 1);
      if (t == 6) begin
        rst_n = 1'b0;
        #1;
        check("up_on_reset", int'(up), 0);
        check("phase_err_on_reset", int'(phase_err), 0);
        last_exp = 0;
      end
      if (t == 8) rst_n = 1'b1;
    end
    push(5, 0);
    window(0, -1, 5, -1, 16, 5, 0);

    // enable dropped mid-interval, fb edge lands while disabled.
    for (int t = 0; t < 24; t++) begin
      step(hit(t, 0), hit(t, 8));
      if (t == 5) enable = 1'b0;
      if (t == 12) begin
        check("up_disabled", int'(up), 0);
        check("phase_err_hold", int'(phase_err), last_exp);
      end
      if (t == 20) enable = 1'b1;
    end
    push(4, 0);
    window(0, -1, 4, -1, 16, 4, 0);

    window(-1, -1, -1, -1, 10, 0, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
